// File: rtl/sphere_arb_pkg.sv
// Shared types and default constants for the sphere RAM read arbiter.
package sphere_arb_pkg;

  localparam int unsigned NReq       = 4;
  localparam int unsigned RdLat      = 2;
  localparam int unsigned MemDepth   = 2000;
  localparam int unsigned AddrW      = 32;
  localparam int unsigned CacheWidth = 512;
  localparam int unsigned IdxW       = (NReq > 1) ? $clog2(NReq) : 1;

  typedef enum logic [0:0] {
    StWaitLoad,
    StArb
  } arb_state_e;

  typedef struct packed {
    logic            valid;
    logic [IdxW-1:0] idx;
    logic            err;
  } rd_tag_t;

endpackage

// File: rtl/sphere_mem_rd_arbiter_rr_arb_core.sv
// One-hot request picker: round robin after ptr_i, or fixed lowest-index priority
// when ARB_FIXED_PRIO_EN is defined (the pointer input then disappears).
module rr_arb_core
  import sphere_arb_pkg::*;
#(
  parameter int unsigned N_REQ = NReq
) (
  input  logic [N_REQ-1:0] req_i,
`ifndef ARB_FIXED_PRIO_EN
  input  logic [IdxW-1:0]  ptr_i,
`endif
  output logic [N_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o
);

  logic found;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
  end
`else
  // Two passes: indices above the pointer first, then wrap to those at or below it.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i] && (i > 32'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && req_i[i] && (i <= 32'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/sphere_mem_rd_arbiter.sv
// Shares the sphere RAM read port among N_REQ engines and returns tagged words after RD_LAT.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module sphere_mem_rd_arbiter
  import sphere_arb_pkg::*;
#(
  // N_REQ must match the package NReq, which sizes the tag index field.
  parameter int unsigned N_REQ       = NReq,
  parameter int unsigned ADDR_W      = AddrW,
  parameter int unsigned CACHE_WIDTH = CacheWidth,
  parameter int unsigned MEM_DEPTH   = MemDepth,
  parameter int unsigned RD_LAT      = RdLat
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    mem_ready_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [ADDR_W-1:0]       ram_rd_addr_o,
  input  logic [CACHE_WIDTH-1:0]  ram_rd_data_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic                    rsp_err_o,
  output logic [CACHE_WIDTH-1:0]  rsp_data_o,
  output logic                    busy_o
);

  arb_state_e        state_q, state_d;
  logic              arb_en;
  logic              grant;
  logic [N_REQ-1:0]  core_gnt;
  logic [IdxW-1:0]   core_idx;
  logic [ADDR_W-1:0] gnt_addr;
  logic [ADDR_W-1:0] ram_rd_addr_q;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;
  rd_tag_t           tag_q [RD_LAT+1];

`ifndef ARB_FIXED_PRIO_EN
  logic [IdxW-1:0] ptr_q;
`endif

  rr_arb_core #(
    .N_REQ (N_REQ)
  ) u_core (
    .req_i (req_i),
`ifndef ARB_FIXED_PRIO_EN
    .ptr_i (ptr_q),
`endif
    .gnt_o (core_gnt),
    .idx_o (core_idx)
  );

  // mem_ready gates grants combinationally: the first grant lands in the cycle it rises,
  // and none issues in the cycle it falls, whatever the registered state says.
  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    unique case (state_q)
      StWaitLoad: begin
        arb_en = mem_ready_i;
        if (mem_ready_i) state_d = StArb;
      end
      StArb: begin
        arb_en = mem_ready_i;
        if (!mem_ready_i) state_d = StWaitLoad;
      end
      default: state_d = StWaitLoad;
    endcase
  end

  assign gnt_o = arb_en ? core_gnt : '0;
  assign grant = arb_en & (|req_i);

  always_comb begin
    gnt_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (core_gnt[i]) gnt_addr = req_addr_i[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    tag_in.valid = grant;
    tag_in.idx   = core_idx;
    tag_in.err   = grant & (gnt_addr >= ADDR_W'(MEM_DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q       <= StWaitLoad;
      ram_rd_addr_q <= '0;
      for (int unsigned i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (grant) ram_rd_addr_q <= gnt_addr;
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      ptr_q <= IdxW'(N_REQ - 1);
    end else if (grant) begin
      ptr_q <= core_idx;
    end
  end
`endif

  // The last tag stage lines up with RAM q for the read it describes.
  assign tag_out       = tag_q[RD_LAT];
  assign ram_rd_addr_o = ram_rd_addr_q;
  assign rsp_valid_o   = tag_out.valid ? (N_REQ'(1) << tag_out.idx) : '0;
  assign rsp_err_o     = tag_out.valid & tag_out.err;
  assign rsp_data_o    = (tag_out.valid && !tag_out.err) ? ram_rd_data_i : '0;

  always_comb begin
    busy_o = 1'b0;
    for (int unsigned i = 0; i <= RD_LAT; i++) busy_o = busy_o | tag_q[i].valid;
  end

endmodule

// File: doc/sphere_mem_rd_arbiter.md
Name: sphere_mem_rd_arbiter

Overview:
Shares the single read port of the sphere RAM (ram_2_ports_d2000_w512, filled by the host-read loader) between N collision engines. Engines present word addresses; the arbiter grants one per cycle and drives the RAM read address. It returns each RAM word, tagged by requester, after the fixed RAM latency. Grants start only after the loader signals the RAM is fully written.

Parameters:
N_REQ, 4, number of requesting engines
ADDR_W, 32, read address width (matches the loader's addr_mem_out)
CACHE_WIDTH, 512, RAM word width
MEM_DEPTH, 2000, valid address range 0..MEM_DEPTH-1
RD_LAT, 2, cycles from RAM rdaddress sampled to q valid

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
mem_ready  in  1  loader done level; RAM contents valid
req  in  N_REQ  per-engine read request, level
req_addr  in  N_REQ*ADDR_W  packed addresses; engine i uses bits [i*ADDR_W +: ADDR_W]
gnt  out  N_REQ  one-hot grant, combinational, same cycle as accept
ram_rd_addr  out  ADDR_W  registered; connects to the loader's addr_mem_out
ram_rd_data  in  CACHE_WIDTH  RAM q (mem_out)
rsp_valid  out  N_REQ  one-hot response strobe, registered
rsp_err  out  1  address out of range for the current response
rsp_data  out  CACHE_WIDTH  response word; zero when rsp_err
busy  out  1  any read in flight

Behaviour:
- Reset (reset_n=0 at posedge): state=WAIT_LOAD, rr pointer=N_REQ-1, ram_rd_addr=0, tag pipeline cleared, rsp_valid=0, rsp_err=0, busy=0.
- Reset mid-operation flushes all in-flight reads. No response is issued for them.
- FSM WAIT_LOAD: gnt=0. Go to ARB when mem_ready=1.
- FSM ARB: if any req is set, grant exactly one. At the clock edge, latch the granted address into ram_rd_addr and push {valid, idx, err} into a tag shift register of depth RD_LAT+1.
- ARB -> WAIT_LOAD when mem_ready=0. mem_ready is sampled combinationally, so no grant is issued in that cycle.
- On the return to WAIT_LOAD, in-flight tags keep shifting and their responses are still delivered (drain).
- Handshake: an engine holds req and req_addr stable until it sees gnt. A req still high in the cycle after gnt counts as a new request, so back-to-back grants are legal.
- Round robin: the search starts at pointer+1 and wraps modulo N_REQ. The pointer updates to the granted index only on a grant.
- Throughput: 1 grant per cycle.
- Latency: gnt in cycle T means rsp_valid[idx] is asserted in cycle T+1+RD_LAT, for exactly one cycle.
- rsp_data = ram_rd_data in that cycle; it is forced to 0 when the tag's err bit is set.
- Address check: req_addr >= MEM_DEPTH is still granted. Its tag err=1. ram_rd_addr is still loaded, but the returned data is discarded and replaced by zero, with rsp_err=1.
- busy = OR of the tag valid bits.
- Width rule: no arithmetic on addresses beyond the unsigned compare with MEM_DEPTH.
- A single requester holding req continuously gets a grant every cycle. With all requesters active, each is granted once per N_REQ cycles.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The rr pointer is removed.
- Undefined: round robin as above. Latency and handshake are identical in both modes.

Decomposition:
- Package sphere_arb_pkg: state enum {WAIT_LOAD, ARB}, tag struct {valid, idx[$clog2(N_REQ)-1:0], err}, default constants N_REQ, RD_LAT, MEM_DEPTH.
- One sub-module rr_arb_core: takes req and pointer, returns one-hot gnt and the encoded index. It holds the ARB_FIXED_PRIO_EN variant.
- The top level holds the FSM, address register and tag pipeline.

Test Plan:
1. Single engine: mem_ready=0 and req[0]=1 with addr 5 -> gnt=0. Raise mem_ready at T -> gnt[0] at T; ram_rd_addr=5 at T+1; rsp_valid[0] with RAM word 5 at T+3.
2. All 4 engines request continuously with addrs 10..13 -> grants cycle 0,1,2,3,0...; each rsp_valid carries the matching word, in order.
3. req[2] with addr 2000 -> granted; at gnt+3: rsp_valid[2]=1, rsp_err=1, rsp_data=0. Then addr 1999 -> rsp_err=0.
4. mem_ready falls one cycle after two grants -> no further gnt; both responses still arrive; busy falls after the last one.
5. reset_n=0 one cycle after a grant -> no rsp_valid follows; all outputs 0; state WAIT_LOAD.
6. ARB_FIXED_PRIO_EN build, req=4'b1010 held -> gnt[1] every cycle; engine 3 is starved until req[1] drops.
